apu_bus_master: RTL and testbench

CPU-side bus initiator for the APU register space (0x4000–0x401F). It accepts queued register read/write commands from a testbench harness or host shim and replays them as CPU-style bus cycles on `Addr_fromcore` / `RnW_fromcore` / data bus, the exact inputs consumed by the APU register address decoder. Each access is framed by an address phase, a PHI2 strobe phase and a hold phase. Read data is returned on a response port. The block lets the APU core be driven and regression-tested without the 6502 core in the loop.

---
 rtl/apu_bus_master.sv | 235 +++++++++++++++++++++++
 tb/tb_apu_bus_master.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_bus_master.sv
// apu_bus_master
// CPU-side bus initiator for the APU register window 0x4000-0x401F.
// Queued register commands are replayed as CPU-style bus cycles made of an
// address phase, a PHI2 strobe phase and a hold phase.
//
// Ports:
//   CLK, RES                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake into the FIFO
//   cmd_rnw/cmd_reg/cmd_data  command fields (read flag, offset, write data)
//   Addr_fromcore, RnW_fromcore, PHI2, DB_out, DB_oe   registered bus outputs
//   DB_in                     read data returned by the APU
//   rsp_valid/rsp_data/rsp_reg  one-clock read response
//   busy, fifo_level          activity and FIFO occupancy
module apu_bus_master #(
    parameter int CYC_LEN    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RES,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_rnw,
    input  logic [4:0]                  cmd_reg,
    input  logic [7:0]                  cmd_data,
    output logic [15:0]                 Addr_fromcore,
    output logic                        RnW_fromcore,
    output logic                        PHI2,
    output logic [7:0]                  DB_out,
    output logic                        DB_oe,
    input  logic [7:0]                  DB_in,
    output logic                        rsp_valid,
    output logic [7:0]                  rsp_data,
    output logic [4:0]                  rsp_reg,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CYC_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // FIFO storage: {rnw, reg, data}
    logic [13:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_s, empty_s, push_s, pop_s;
    logic [13:0]      head_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cur_rnw_q, cur_rnw_d;
    logic [4:0]       cur_reg_q, cur_reg_d;
    logic [7:0]       cur_data_q, cur_data_d;

    logic [15:0]      addr_q, addr_d;
    logic             rnw_q, rnw_d;
    logic             phi2_q, phi2_d;
    logic [7:0]       db_out_q, db_out_d;
    logic             db_oe_q, db_oe_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [4:0]       rsp_reg_q, rsp_reg_d;

    // FIFO status; full/empty come from the registered level only
    always_comb begin
        full_s  = (level_q == LVL_W'(FIFO_DEPTH));
        empty_s = (level_q == {LVL_W{1'b0}});
        push_s  = cmd_valid && !full_s;
        head_s  = mem_q[rd_ptr_q];
    end

    // Sequencer: pops in IDLE or HOLD, walks ADDR -> DATA (counted) -> HOLD
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_rnw_d  = cur_rnw_q;
        cur_reg_d  = cur_reg_q;
        cur_data_d = cur_data_q;
        pop_s      = 1'b0;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    state_d    = S_ADDR;
                    cur_rnw_d  = head_s[13];
                    cur_reg_d  = head_s[12:8];
                    cur_data_d = head_s[7:0];
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_ADDR: begin
                state_d = S_DATA;
                cnt_d   = CNT_W'(CYC_LEN - 3);
            end
            S_DATA: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus/response next values derived from the next state, so outputs are registered
    always_comb begin
        addr_d      = 16'h0000;
        rnw_d       = 1'b1;
        phi2_d      = 1'b0;
        db_oe_d     = 1'b0;
        db_out_d    = db_out_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_reg_d   = rsp_reg_q;
        if (state_d != S_IDLE) begin
            addr_d = {11'h200, cur_reg_d};
            rnw_d  = cur_rnw_d;
        end else begin
            addr_d = 16'h0000;
            rnw_d  = 1'b1;
        end
        if (state_d == S_DATA) begin
            phi2_d  = 1'b1;
            db_oe_d = !cur_rnw_d;
        end else begin
            phi2_d  = 1'b0;
            db_oe_d = 1'b0;
        end
        if (db_oe_d) begin
            db_out_d = cur_data_d;
        end else begin
            db_out_d = db_out_q;
        end
        // DB_in is sampled on the edge that leaves DATA
        if ((state_q == S_DATA) && (state_d == S_HOLD) && cur_rnw_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = DB_in;
            rsp_reg_d   = cur_reg_q;
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // FIFO pointer and level bookkeeping
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write port (contents need no reset; pointers define validity)
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cmd_rnw, cmd_reg, cmd_data};
        end
    end

    // State, FIFO control and output registers
    always_ff @(posedge CLK) begin
        if (RES) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            cur_rnw_q   <= 1'b1;
            cur_reg_q   <= 5'd0;
            cur_data_q  <= 8'h00;
            addr_q      <= 16'h0000;
            rnw_q       <= 1'b1;
            phi2_q      <= 1'b0;
            db_out_q    <= 8'h00;
            db_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_reg_q   <= 5'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_rnw_q   <= cur_rnw_d;
            cur_reg_q   <= cur_reg_d;
            cur_data_q  <= cur_data_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            phi2_q      <= phi2_d;
            db_out_q    <= db_out_d;
            db_oe_q     <= db_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_reg_q   <= rsp_reg_d;
        end
    end

    assign cmd_ready     = !full_s;
    assign busy          = (state_q != S_IDLE) || !empty_s;
    assign fifo_level    = level_q;
    assign Addr_fromcore = addr_q;
    assign RnW_fromcore  = rnw_q;
    assign PHI2          = phi2_q;
    assign DB_out        = db_out_q;
    assign DB_oe         = db_oe_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_reg       = rsp_reg_q;

endmodule

// File: tb/tb_apu_bus_master.sv
// Bench for apu_bus_master: transaction-level reference model compared every
// clock, a table of isolated accesses, and directed multi-cycle sequences.
module tb_apu_bus_master;

    localparam int CL    = 4;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RES;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [4:0]  cmd_reg;
    logic [7:0]  cmd_data;
    logic [15:0] Addr_fromcore;
    logic        RnW_fromcore, PHI2, DB_oe;
    logic [7:0]  DB_out, DB_in;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [4:0]  rsp_reg;
    logic        busy;
    logic [2:0]  fifo_level;

    // second instance with the shortest bus cycle
    logic        cmd_valid3, cmd_ready3;
    logic [15:0] addr3;
    logic        rnw3, phi2_3, oe3, rv3, busy3;
    logic [7:0]  dbo3, db_in3, rd3;
    logic [4:0]  rr3;
    logic [2:0]  lvl3;

    always #5 CLK = ~CLK;

    apu_bus_master #(.CYC_LEN(CL), .FIFO_DEPTH(DEPTH)) u_dut (
        .CLK(CLK), .RES(RES), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rnw(cmd_rnw), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .Addr_fromcore(Addr_fromcore), .RnW_fromcore(RnW_fromcore), .PHI2(PHI2),
        .DB_out(DB_out), .DB_oe(DB_oe), .DB_in(DB_in), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_reg(rsp_reg), .busy(busy), .fifo_level(fifo_level)
    );

    apu_bus_master #(.CYC_LEN(3), .FIFO_DEPTH(4)) u_dut3 (
        .CLK(CLK), .RES(RES), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_rnw(1'b1), .cmd_reg(5'h16), .cmd_data(8'h00),
        .Addr_fromcore(addr3), .RnW_fromcore(rnw3), .PHI2(phi2_3),
        .DB_out(dbo3), .DB_oe(oe3), .DB_in(db_in3), .rsp_valid(rv3),
        .rsp_data(rd3), .rsp_reg(rr3), .busy(busy3), .fifo_level(lvl3)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        logic       rnw;
        logic [4:0] rg;
        logic [7:0] data;
    } cmd_t;

    cmd_t        mq[$];
    cmd_t        m_cur;
    bit          m_active = 1'b0;
    int          m_pos = 0;
    bit          model_en = 1'b0;
    logic [15:0] e_addr;
    logic        e_rnw, e_phi2, e_oe, e_rv;
    logic [7:0]  e_dbo, e_rd;
    logic [4:0]  e_rr;

    // A bus cycle is CL clocks: position 0 address, 1..CL-2 strobe, CL-1 hold
    always @(posedge CLK) begin
        int lvl;
        bit acc;
        if (RES) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            e_dbo    = 8'h00;
            e_rd     = 8'h00;
            e_rr     = 5'd0;
            e_rv     = 1'b0;
        end else begin
            lvl  = mq.size();
            acc  = cmd_valid && (lvl < DEPTH);
            e_rv = 1'b0;
            if (m_active && m_pos < CL - 1) begin
                m_pos++;
                if (m_pos == CL - 1 && m_cur.rnw) begin
                    e_rv = 1'b1;
                    e_rd = DB_in;
                    e_rr = m_cur.rg;
                end
            end else if (lvl > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end else begin
                m_active = 1'b0;
            end
            if (acc) mq.push_back({cmd_rnw, cmd_reg, cmd_data});
        end
        if (m_active) begin
            e_addr = 16'h4000 + {11'd0, m_cur.rg};
            e_rnw  = m_cur.rnw;
            e_phi2 = (m_pos >= 1) && (m_pos <= CL - 2);
            e_oe   = e_phi2 && !m_cur.rnw;
            if (e_oe) e_dbo = m_cur.data;
        end else begin
            e_addr = 16'h0000;
            e_rnw  = 1'b1;
            e_phi2 = 1'b0;
            e_oe   = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (model_en) begin
            chk("addr",      Addr_fromcore, e_addr);
            chk("rnw",       RnW_fromcore,  e_rnw);
            chk("phi2",      PHI2,          e_phi2);
            chk("db_oe",     DB_oe,         e_oe);
            chk("db_out",    DB_out,        e_dbo);
            chk("rsp_valid", rsp_valid,     e_rv);
            chk("rsp_data",  rsp_data,      e_rd);
            chk("rsp_reg",   rsp_reg,       e_rr);
            chk("level",     fifo_level,    mq.size());
            chk("ready",     cmd_ready,     mq.size() < DEPTH);
            chk("busy",      busy,          m_active || (mq.size() > 0));
        end
    end

    // access-start monitor: a new non-zero address marks an ADDR phase
    int          st_cyc[$];
    logic [4:0]  st_reg[$];
    logic [15:0] prev_addr = 16'h0000;
    bit          mon_en = 1'b0;

    always @(negedge CLK) begin
        if (mon_en && Addr_fromcore != prev_addr && Addr_fromcore != 16'h0000) begin
            st_cyc.push_back(cyc);
            st_reg.push_back(Addr_fromcore[4:0]);
        end
        prev_addr = Addr_fromcore;
    end

    // offer one command at a negedge until accepted, bounded
    task automatic push_cmd(input logic rnw, input logic [4:0] rg, input logic [7:0] d);
        bit ok;
        bit done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_reg   = rg;
        cmd_data  = d;
        for (int t = 0; t < 50 && !done; t++) begin
            ok = cmd_ready;
            @(negedge CLK);
            if (ok) done = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("push_timeout", done, 1'b1);
    endtask

    typedef struct {
        logic        rnw;
        logic [4:0]  rg;
        logic [7:0]  data;
        logic [7:0]  dbin;
        logic [15:0] ex_addr;
        int          ex_rsp;
        logic [7:0]  ex_rd;
    } vec_t;

    vec_t tv[5];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int na, np, no, nbad, nr, i3;
        logic [7:0] rd;
        logic [4:0] rr;
        bit w_done;

        tv[0] = '{1'b0, 5'h15, 8'h0F, 8'h00, 16'h4015, 0, 8'h00};
        tv[1] = '{1'b1, 5'h15, 8'h00, 8'h5A, 16'h4015, 1, 8'h5A};
        tv[2] = '{1'b1, 5'h00, 8'h33, 8'hA3, 16'h4000, 1, 8'hA3};
        tv[3] = '{1'b0, 5'h1F, 8'hFF, 8'h12, 16'h401F, 0, 8'h00};
        tv[4] = '{1'b1, 5'h1F, 8'h00, 8'h00, 16'h401F, 1, 8'h00};

        RES = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_reg = 5'd0; cmd_data = 8'h00;
        DB_in = 8'h00; cmd_valid3 = 1'b0; db_in3 = 8'h11;
        repeat (3) @(negedge CLK);

        // reset state
        chk("rst_addr",  Addr_fromcore, 16'h0000);
        chk("rst_rnw",   RnW_fromcore,  1'b1);
        chk("rst_phi2",  PHI2,          1'b0);
        chk("rst_oe",    DB_oe,         1'b0);
        chk("rst_dbo",   DB_out,        8'h00);
        chk("rst_rv",    rsp_valid,     1'b0);
        chk("rst_rd",    rsp_data,      8'h00);
        chk("rst_rr",    rsp_reg,       5'd0);
        chk("rst_level", fifo_level,    3'd0);
        chk("rst_ready", cmd_ready,     1'b1);
        chk("rst_busy",  busy,          1'b0);
        RES      = 1'b0;
        model_en = 1'b1;

        // table of isolated accesses
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_rnw = tv[i].rnw; cmd_reg = tv[i].rg;
            cmd_data = tv[i].data; DB_in = tv[i].dbin;
            @(negedge CLK);
            cmd_valid = 1'b0;
            na = 0; np = 0; no = 0; nbad = 0; nr = 0; rd = 8'h00; rr = 5'd0;
            repeat (10) begin
                @(negedge CLK);
                if (Addr_fromcore == tv[i].ex_addr) na++;
                if (PHI2) np++;
                if (DB_oe) begin
                    no++;
                    if (DB_out !== tv[i].data) nbad++;
                end
                if (rsp_valid) begin nr++; rd = rsp_data; rr = rsp_reg; end
            end
            chk("tv_addr_clocks", na, 4);
            chk("tv_phi2_clocks", np, 2);
            chk("tv_oe_clocks",   no, tv[i].rnw ? 0 : 2);
            chk("tv_dbout",       nbad, 0);
            chk("tv_rsp_count",   nr, tv[i].ex_rsp);
            if (tv[i].ex_rsp != 0) begin
                chk("tv_rsp_data", rd, tv[i].ex_rd);
                chk("tv_rsp_reg",  rr, tv[i].rg);
            end
            chk("tv_addr_idle", Addr_fromcore, 16'h0000);
        end

        // burst of 5 into depth-4 FIFO, then a push on a pop edge at level 3
        st_cyc.delete(); st_reg.delete(); mon_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            DB_in = 8'($urandom_range(0, 255));
            push_cmd(k[0], 5'(k + 1), 8'(8'h40 + k));
        end
        chk("burst_level4", fifo_level, 3'd4);
        chk("burst_notready", cmd_ready, 1'b0);
        w_done = 1'b0;
        for (int t = 0; t < 40 && !w_done; t++) begin
            if (fifo_level == 3'd3) w_done = 1'b1;
            else @(negedge CLK);
        end
        chk("wait_level3", w_done, 1'b1);
        repeat (3) @(negedge CLK);
        push_cmd(1'b1, 5'd6, 8'h00);
        chk("pushpop_level", fifo_level, 3'd3);
        w_done = 1'b0;
        for (int t = 0; t < 100 && !w_done; t++) begin
            @(negedge CLK);
            if (!busy) w_done = 1'b1;
        end
        chk("drain", w_done, 1'b1);
        mon_en = 1'b0;
        chk("burst_starts", st_cyc.size(), 6);
        if (st_cyc.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("burst_order", st_reg[k], 5'(k + 1));
            for (int k = 1; k < 6; k++) chk("burst_spacing", st_cyc[k] - st_cyc[k-1], CL);
        end

        // reset during DATA of a write with two commands queued
        push_cmd(1'b0, 5'h15, 8'hAA);
        push_cmd(1'b1, 5'h02, 8'h00);
        push_cmd(1'b0, 5'h03, 8'h55);
        w_done = 1'b0;
        for (int t = 0; t < 20 && !w_done; t++) begin
            if (PHI2 && DB_oe) w_done = 1'b1;
            else @(negedge CLK);
        end
        chk("wait_write_data", w_done, 1'b1);
        chk("queued_before_res", fifo_level, 3'd2);
        RES = 1'b1;
        @(negedge CLK);
        RES = 1'b0;
        chk("res_addr",  Addr_fromcore, 16'h0000);
        chk("res_rnw",   RnW_fromcore,  1'b1);
        chk("res_phi2",  PHI2,          1'b0);
        chk("res_oe",    DB_oe,         1'b0);
        chk("res_level", fifo_level,    3'd0);
        st_cyc.delete(); st_reg.delete(); mon_en = 1'b1;
        nr = 0;
        repeat (10) begin
            @(negedge CLK);
            if (rsp_valid) nr++;
        end
        mon_en = 1'b0;
        chk("res_no_cycles", st_cyc.size(), 0);
        chk("res_no_rsp", nr, 0);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_rnw   = 1'($urandom_range(0, 1));
            cmd_reg   = 5'($urandom_range(0, 31));
            cmd_data  = 8'($urandom_range(0, 255));
            DB_in     = 8'($urandom_range(0, 255));
            RES       = ($urandom_range(0, 149) == 0);
            @(negedge CLK);
        end
        cmd_valid = 1'b0; RES = 1'b0;
        w_done = 1'b0;
        for (int t = 0; t < 100 && !w_done; t++) begin
            @(negedge CLK);
            if (!busy) w_done = 1'b1;
        end
        chk("rand_drain", w_done, 1'b1);

        // CYC_LEN=3 read of 0x4016: one strobe clock, data taken from it
        cmd_valid3 = 1'b1;
        @(negedge CLK);
        cmd_valid3 = 1'b0;
        db_in3 = 8'h11;
        na = 0; np = 0; nr = 0; rd = 8'h00; rr = 5'd0; i3 = 0;
        repeat (8) begin
            @(negedge CLK);
            if (addr3 == 16'h4016) na++;
            if (phi2_3) np++;
            if (rv3) begin nr++; rd = rd3; rr = rr3; end
            db_in3 = phi2_3 ? 8'h77 : 8'h11;
        end
        chk("c3_addr_clocks", na, 3);
        chk("c3_phi2_clocks", np, 1);
        chk("c3_rsp_count",   nr, 1);
        chk("c3_rsp_data",    rd, 8'h77);
        chk("c3_rsp_reg",     rr, 5'h16);
        chk("c3_idle",        addr3, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
